// File: rtl/plot_arbiter.sv
// plot_arbiter
// Round-robin arbiter that merges pixel writes from four requesters into a
// single registered write port for a VGA adapter. Each requester owns a
// one-entry buffer, so it can post a pixel and move on while the sink is
// busy serving someone else.
//
// Ports
//   clk                      system clock, all state on its rising edge
//   reset                    asynchronous active-high reset
//   x_in0..x_in3   [7:0]     pixel x from requester i
//   y_in0..y_in3   [6:0]     pixel y from requester i
//   colour_in0..3  [2:0]     pixel colour from requester i
//   plot0..plot3             write strobe from requester i
//   vga_stall                sink refuses writes this cycle
//   ready0..ready3           combinational: requester i's buffer can accept
//   vga_x/vga_y/vga_colour   registered pixel to the adapter
//   vga_plot                 registered write strobe to the adapter
//   overflow       [3:0]     sticky per-requester "a write was dropped" flag

module plot_arbiter #(
  parameter int X_MAX = 159,
  parameter int Y_MAX = 119
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] x_in0,
  input  logic [7:0] x_in1,
  input  logic [7:0] x_in2,
  input  logic [7:0] x_in3,
  input  logic [6:0] y_in0,
  input  logic [6:0] y_in1,
  input  logic [6:0] y_in2,
  input  logic [6:0] y_in3,
  input  logic [2:0] colour_in0,
  input  logic [2:0] colour_in1,
  input  logic [2:0] colour_in2,
  input  logic [2:0] colour_in3,
  input  logic       plot0,
  input  logic       plot1,
  input  logic       plot2,
  input  logic       plot3,
  input  logic       vga_stall,
  output logic       ready0,
  output logic       ready1,
  output logic       ready2,
  output logic       ready3,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_plot,
  output logic [3:0] overflow
);

  localparam logic [7:0] X_LIM = 8'(X_MAX);
  localparam logic [6:0] Y_LIM = 7'(Y_MAX);

  logic [7:0] x_arr [4];
  logic [6:0] y_arr [4];
  logic [2:0] c_arr [4];
  logic [3:0] plot_vec;

  logic [7:0] buf_x [4];
  logic [6:0] buf_y [4];
  logic [2:0] buf_c [4];
  logic [3:0] pending;

  logic [1:0] last_grant;
  logic [1:0] grant_idx;
  logic       grant_valid;
  logic [3:0] grant;
  logic [3:0] ready;
  logic [3:0] in_range;
  logic [3:0] capture;
  logic [3:0] drop;

  assign x_arr[0] = x_in0;
  assign x_arr[1] = x_in1;
  assign x_arr[2] = x_in2;
  assign x_arr[3] = x_in3;
  assign y_arr[0] = y_in0;
  assign y_arr[1] = y_in1;
  assign y_arr[2] = y_in2;
  assign y_arr[3] = y_in3;
  assign c_arr[0] = colour_in0;
  assign c_arr[1] = colour_in1;
  assign c_arr[2] = colour_in2;
  assign c_arr[3] = colour_in3;
  assign plot_vec = {plot3, plot2, plot1, plot0};

  assign ready0 = ready[0];
  assign ready1 = ready[1];
  assign ready2 = ready[2];
  assign ready3 = ready[3];

  // Round-robin pick: scan from last_grant+1 upward (wrapping) and take the
  // first pending requester. The first hit wins, so later hits are ignored.
  always_comb begin
    grant_idx   = 2'd0;
    grant_valid = 1'b0;
    if (!vga_stall) begin
      for (int off = 1; off <= 4; off++) begin
        if (!grant_valid && pending[last_grant + 2'(off)]) begin
          grant_idx   = last_grant + 2'(off);
          grant_valid = 1'b1;
        end
      end
    end
  end

  // A granted buffer empties at this edge, so it can be refilled at the same
  // edge; that is why ready includes the grant and not just !pending.
  always_comb begin
    grant    = '0;
    ready    = '0;
    in_range = '0;
    capture  = '0;
    drop     = '0;
    for (int i = 0; i < 4; i++) begin
      grant[i]    = grant_valid && (grant_idx == 2'(i));
      ready[i]    = !pending[i] || grant[i];
      in_range[i] = (x_arr[i] <= X_LIM) && (y_arr[i] <= Y_LIM);
      capture[i]  = plot_vec[i] && ready[i] && in_range[i];
      drop[i]     = plot_vec[i] && !ready[i] && in_range[i];
    end
  end

  // Buffers and pending bits. A same-edge capture beats the grant's clear so
  // the freshly written pixel is not lost behind the one being sent out.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending <= '0;
      for (int i = 0; i < 4; i++) begin
        buf_x[i] <= '0;
        buf_y[i] <= '0;
        buf_c[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (capture[i]) begin
          buf_x[i]   <= x_arr[i];
          buf_y[i]   <= y_arr[i];
          buf_c[i]   <= c_arr[i];
          pending[i] <= 1'b1;
        end else if (grant[i]) begin
          pending[i] <= 1'b0;
        end
      end
    end
  end

  // Output register and arbitration history. last_grant resets to 3 so
  // requester 0 is first in line after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
      vga_plot   <= 1'b0;
      last_grant <= 2'd3;
    end else if (grant_valid) begin
      vga_x      <= buf_x[grant_idx];
      vga_y      <= buf_y[grant_idx];
      vga_colour <= buf_c[grant_idx];
      vga_plot   <= 1'b1;
      last_grant <= grant_idx;
    end else begin
      vga_plot   <= 1'b0;
    end
  end

  // Overflow flags only ever accumulate; reset is the sole way to clear them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow <= '0;
    end else begin
      overflow <= overflow | drop;
    end
  end

endmodule
